// File: rtl/audio_codec_pkg.sv
// audio_codec_pkg: shared widths and FSM state for the I2S codec interface
package audio_codec_pkg;
   localparam int SAMPLE_W = 16;
   localparam int FRAME_BITS = 32;
   localparam int CNT_W = $clog2(FRAME_BITS);
   typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/bclk_gen.sv
// bclk_gen: divides clk down to the codec bit clock and flags its edges
module bclk_gen #(
   parameter int BCLK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   output logic bclk,
   output logic rise_tick,
   output logic fall_tick
);
   logic [7:0] div_cnt;
   logic tick;
   always_comb begin
      tick = run && div_cnt == 8'(BCLK_DIV - 1);
      rise_tick = tick && !bclk;
      fall_tick = tick && bclk;
   end
   always_ff @(posedge clk)
      if (reset || !run) begin
         div_cnt <= '0;
         bclk <= 1'b0;
      end else if (tick) begin
         div_cnt <= '0;
         bclk <= ~bclk;
      end else
         div_cnt <= div_cnt + 8'd1;
endmodule

// File: rtl/audio_codec_i2s.sv
// audio_codec_i2s: left-justified I2S master, mono DAC out and left-channel ADC capture
module audio_codec_i2s
   import audio_codec_pkg::*;
#(
   parameter int BCLK_DIV = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic [SAMPLE_W-1:0] sample_data,
   output logic                sample_req,
   output logic                sample_end,
   output logic [SAMPLE_W-1:0] audio_input,
   output logic                AUD_BCLK,
   output logic                AUD_LRCK,
   output logic                AUD_DACDAT,
   input  logic                AUD_ADCDAT
);
   state_t state;
   logic [CNT_W-1:0] bit_cnt, bit_nxt;
   logic [SAMPLE_W-1:0] hold_reg, tx_sr, tx_src, rx_sr, rx_nxt;
   logic rise_tick, fall_tick;
   bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk (
      .clk(clk),
      .reset(reset),
      .run(state == RUN),
      .bclk(AUD_BCLK),
      .rise_tick(rise_tick),
      .fall_tick(fall_tick)
   );
   // the right half replays hold_reg, so both channels carry the same sample
   always_comb begin
      bit_nxt = bit_cnt + CNT_W'(1);
      rx_nxt = {rx_sr[SAMPLE_W-2:0], AUD_ADCDAT};
      tx_src = bit_nxt == '0 ? sample_data : bit_nxt == CNT_W'(16) ? hold_reg : tx_sr;
   end
   always_ff @(posedge clk)
      if (reset) begin
         state <= IDLE;
         bit_cnt <= '0;
         hold_reg <= '0;
         tx_sr <= '0;
         rx_sr <= '0;
         audio_input <= '0;
         AUD_LRCK <= 1'b0;
         AUD_DACDAT <= 1'b0;
         sample_req <= 1'b0;
         sample_end <= 1'b0;
      end else begin
         sample_req <= 1'b0;
         sample_end <= 1'b0;
         if (state == IDLE) begin
            if (enable) begin
               state <= RUN;
               bit_cnt <= '1;
               sample_req <= 1'b1;
            end
         end else if (fall_tick) begin
            if (bit_nxt == '0 && !enable) begin
               state <= IDLE;
               bit_cnt <= '0;
               AUD_LRCK <= 1'b0;
               AUD_DACDAT <= 1'b0;
            end else begin
               bit_cnt <= bit_nxt;
               AUD_LRCK <= bit_nxt[CNT_W-1];
               {AUD_DACDAT, tx_sr} <= {tx_src, 1'b0};
               if (bit_nxt == '0) hold_reg <= sample_data;
               sample_req <= enable && bit_nxt == '1;
            end
         end else if (rise_tick && !bit_cnt[CNT_W-1]) begin
            rx_sr <= rx_nxt;
            if (bit_cnt == CNT_W'(15)) begin
               audio_input <= rx_nxt;
               sample_end <= 1'b1;
            end
         end
      end
endmodule

// File: doc/audio_codec_i2s.md
AUDIO_CODEC_I2S -- requirements
Module: audio_codec_i2s

Interface
REQ-001 SHALL have parameter BCLK_DIV, default 4: clk cycles per BCLK half-period; legal range 2..255.
REQ-002 SHALL have port clk  input  1  the single system/audio clock; every register is clocked on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have port enable  input  1  run request; level-sensitive.
REQ-005 SHALL have port sample_data  input  16  two's-complement DAC sample supplied by the sample source.
REQ-006 SHALL have port sample_req  output  1  one-cycle pulse requesting the next sample_data.
REQ-007 SHALL have port sample_end  output  1  one-cycle pulse; audio_input holds a new ADC sample.
REQ-008 SHALL have port audio_input  output  16  last captured left-channel ADC sample.
REQ-009 SHALL have port AUD_BCLK  output  1  bit clock to the codec.
REQ-010 SHALL have port AUD_LRCK  output  1  frame clock, shared by DAC and ADC: 0 = left, 1 = right.
REQ-011 SHALL have port AUD_DACDAT  output  1  serial DAC data, MSB first.
REQ-012 SHALL have port AUD_ADCDAT  input  1  serial ADC data, MSB first.

Function
REQ-013 SHALL implement FSM states IDLE and RUN.
REQ-014 SHALL move IDLE->RUN on the first clk with enable=1, loading bit_cnt=31, div_cnt=0 and AUD_BCLK=0, and pulsing sample_req in that same cycle.
REQ-015 SHALL, in RUN only, count div_cnt 0..BCLK_DIV-1 and toggle AUD_BCLK when div_cnt=BCLK_DIV-1 (a "tick"), giving a BCLK period of 2*BCLK_DIV clk cycles.
REQ-016 SHALL, on a falling tick (AUD_BCLK 1->0), advance bit_cnt modulo 32, drive AUD_LRCK=bit_cnt_new[4] and drive AUD_DACDAT with the next shift-register MSB (left-justified format: MSB coincides with the LRCK edge).
REQ-017 SHALL, on the falling tick into bit_cnt 0, latch sample_data into hold_reg and load the TX shift register from sample_data.
REQ-018 SHALL, on the falling tick into bit_cnt 16, reload the TX shift register from hold_reg, so the output is mono with an identical right channel.
REQ-019 SHALL, on the falling tick into bit_cnt 31, pulse sample_req for exactly one clk cycle when enable=1; the source then has 2*BCLK_DIV-1 clk cycles to update sample_data.
REQ-020 SHALL, on each rising tick with bit_cnt<16, shift AUD_ADCDAT into the RX shift register, and SHALL ignore the right-channel ADC bits.
REQ-021 SHALL, on the rising tick at bit_cnt=15, write the completed 16-bit word to audio_input, and assert sample_end for the single following clk cycle while audio_input is stable.
REQ-022 SHALL hold audio_input unchanged between captures.
REQ-023 SHALL, when enable=0 in RUN, finish the current frame; at the falling tick that would wrap bit_cnt 31->0 it SHALL enter IDLE with AUD_BCLK=0, AUD_LRCK=0 and AUD_DACDAT=0.
REQ-024 SHALL suppress sample_req while enable=0; a re-assertion of enable before the wrap SHALL keep RUN without a gap in BCLK.
REQ-025 SHALL hold all serial outputs static in IDLE and never pulse sample_req or sample_end there.

Reset
REQ-026 SHALL, when reset=1, force state=IDLE; AUD_BCLK, AUD_LRCK, AUD_DACDAT, sample_req and sample_end to 0; audio_input, hold_reg and both shift registers to 16'h0000; and bit_cnt and div_cnt to 0.
REQ-027 SHALL give reset priority over enable and over ticks, including mid-frame; no pulse SHALL be emitted in the reset cycle.

Structure
REQ-028 SHALL take SAMPLE_W=16, FRAME_BITS=32 and the state enum from shared package audio_codec_pkg.
REQ-029 SHALL place div_cnt, the BCLK toggle and the rise/fall tick strobes in sub-module bclk_gen.

Verification
REQ-030 SHALL verify reset: BCLK_DIV=4, reset held 3 cycles -> all outputs 0 and AUD_BCLK static until enable is asserted.
REQ-031 SHALL verify TX: sample_data=16'hA5C3 answered on sample_req -> AUD_DACDAT carries 1010010111000011 in the left half and again in the right half, with the BCLK period = 8 clk and a frame = 256 clk.
REQ-032 SHALL verify RX: AUD_ADCDAT drives 16'h8001 left and 16'hFFFF right -> audio_input=16'h8001 with a single-cycle sample_end, then no further update until the next frame.
REQ-033 SHALL verify request spacing: sample_req pulses exactly once per 256 clk with sample_data latched 7 clk after each pulse, including when the source updates sample_data one cycle after sample_req.
REQ-034 SHALL verify disable: enable dropped at bit_cnt=5 -> the frame completes, the FSM enters IDLE at the wrap, and no sample_req occurs at bit 31.
REQ-035 SHALL verify reset mid-frame: reset at bit_cnt=20 -> outputs cleared next cycle, and a restart emits sample_req on the first enabled cycle.
